alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Sequential front-end that drives the combinational 64-bit ALU (inputs a/b/sel, 128-bit result c).
//  - Accepts operation commands over a valid/ready interface and buffers them in a FIFO.
//  - Holds each command on the ALU inputs for a settle window, then captures c.
//  - Returns each result in order over a valid/ready response interface.
// PARAMETERS
//  DATA_W         64  operand width (ALU a/b); result width is 2*DATA_W
//  FIFO_DEPTH     4   command FIFO entries, power of two, >=2
//  SETTLE_CYCLES  2   cycles ALU inputs are held before c is captured, >=1
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         FIFO can accept a command (= !full)
//  cmd_a      in   DATA_W    operand A
//  cmd_b      in   DATA_W    operand B
//  cmd_sel    in   5         ALU opcode
//  alu_a      out  DATA_W    registered drive to ALU a
//  alu_b      out  DATA_W    registered drive to ALU b
//  alu_sel    out  5         registered drive to ALU sel
//  alu_c      in   2*DATA_W  ALU result
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         consumer accepts response
//  rsp_data   out  2*DATA_W  captured result, no truncation
//  rsp_sel    out  5         opcode of this response
//  rsp_err    out  1         divide-by-zero flag (0 when the guard is compiled out)
//  busy       out  1         state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0 except cmd_ready=1; FIFO flushed; FSM to IDLE. An in-flight op is discarded; no response is produced for it.
//  - Push: cmd_valid&cmd_ready. Pop: FSM load. Push and pop in the same cycle leave the count unchanged. No push when full (ready low); no pop when empty.
//  - FSM IDLE: FIFO non-empty -> pop head into alu_a/b/sel, cnt=SETTLE_CYCLES-1 -> SETTLE.
//  - FSM SETTLE: cnt!=0 -> cnt--. cnt==0 -> rsp_data<=alu_c, rsp_sel<=alu_sel, rsp_valid<=1 -> RESP.
//  - FSM RESP: hold rsp_* stable while !rsp_ready. On handshake: rsp_valid<=0; if FIFO non-empty, pop and load in the same edge -> SETTLE; else -> IDLE.
//  - Latency: push into empty idle block at edge E0 -> rsp_valid high after edge E0+SETTLE_CYCLES+1.
//  - Throughput with rsp_ready=1: one response per SETTLE_CYCLES+1 cycles.
//  - alu_a/b/sel keep the last issued value between ops; they never change during SETTLE.
//  - Responses are strictly in command order; every accepted command yields exactly one response.
//  - Opcodes are passed through unchecked; unknown codes are issued as-is.
// CONFIGURATION
//  ALU_DIV0_GUARD_EN defined:
//    - A popped command with sel==DIV(00011) or MOD(00100) and b==0 is not issued.
//    - alu_* stay unchanged; next edge rsp_valid=1, rsp_data=0, rsp_err=1, rsp_sel=sel; FSM -> RESP.
//  Macro undefined:
//    - Such commands are issued normally; rsp_err is tied 0.
// STRUCTURE
//  - alu_pkg:
//    - opcode localparams OP_ADD=00000 SUB=00001 MUL=00010 DIV=00011 MOD=00100 ... GT=10101
//    - OP_W=5
//    - FSM state encoding IDLE/SETTLE/RESP
//  - Sub-module alu_cmd_fifo:
//    - sync FIFO, width DATA_W*2+5, depth FIFO_DEPTH
//    - full/empty from a count register; async active-low reset
// TESTING
//  1 Reset: rst_n=0 mid-run -> rsp_valid=0, alu_*=0, cmd_ready=1, busy=0 immediately.
//  2 ADD a=100 b=50 sel=00000, real ALU, rsp_ready=1 -> rsp_data=150, rsp_sel=00000, rsp_err=0, exactly SETTLE_CYCLES+1 edges after push.
//  3 Backpressure, rsp_ready=0: push 6 SUB cmds (a=200 b=75..80) -> 1 issued + 4 queued, then cmd_ready=0.
//    - rsp_data=125 stays stable.
//    - After release: results 125,124,...,120 in order.
//  4 Back-to-back, 2 cmds, rsp_ready=1 -> rsp_valid pulses separated by SETTLE_CYCLES+1 cycles.
//  5 DIV a=500 b=0 sel=00011:
//    - macro defined -> rsp_err=1, rsp_data=0, alu_sel unchanged.
//    - undefined -> issued, rsp_err=0.
//  6 Reset asserted during SETTLE with 2 queued -> after release no rsp_valid, FIFO empty, busy=0.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_cmd_issuer_pkg
// Purpose  : Shared constants for the ALU command issuer. These are the
//            opcode encodings of the attached ALU, the opcode width, and
//            the issuer FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package alu_cmd_issuer_pkg;

    localparam int OP_W = 5;

    typedef logic [OP_W-1:0] opcode_t;
    typedef logic [1:0]      state_t;

    // ALU opcode map. Codes that are not listed here still pass through untouched.
    localparam opcode_t OP_ADD  = 5'b00000;
    localparam opcode_t OP_SUB  = 5'b00001;
    localparam opcode_t OP_MUL  = 5'b00010;
    localparam opcode_t OP_DIV  = 5'b00011;
    localparam opcode_t OP_MOD  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_XOR  = 5'b00111;
    localparam opcode_t OP_NOT  = 5'b01000;
    localparam opcode_t OP_SHL  = 5'b01001;
    localparam opcode_t OP_SHR  = 5'b01010;
    localparam opcode_t OP_SRA  = 5'b01011;
    localparam opcode_t OP_ROL  = 5'b01100;
    localparam opcode_t OP_ROR  = 5'b01101;
    localparam opcode_t OP_NAND = 5'b01110;
    localparam opcode_t OP_NOR  = 5'b01111;
    localparam opcode_t OP_XNOR = 5'b10000;
    localparam opcode_t OP_EQ   = 5'b10001;
    localparam opcode_t OP_NE   = 5'b10010;
    localparam opcode_t OP_LT   = 5'b10011;
    localparam opcode_t OP_LE   = 5'b10100;
    localparam opcode_t OP_GT   = 5'b10101;

    // Issuer FSM state encoding
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // True for the operations whose divisor is operand B
    function automatic logic is_div_op(input opcode_t sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_cmd_issuer_if
// Purpose  : Bundles the command channel, the ALU drive/result bus, the
//            response channel and the busy flag of the ALU command issuer.
//            The slave modport is the issuer side. The master modport is
//            the environment side (command source, ALU, response sink).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_cmd_issuer_if
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DATA_W = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    logic [OP_W-1:0]       cmd_sel;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [OP_W-1:0]       alu_sel;
    logic [2*DATA_W-1:0]   alu_c;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_data;
    logic [OP_W-1:0]       rsp_sel;
    logic                  rsp_err;

    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_c, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
               rsp_valid, rsp_data, rsp_sel, rsp_err, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_c, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
               rsp_valid, rsp_data, rsp_sel, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_cmd_fifo
// Purpose  : Synchronous show-ahead FIFO for packed issuer commands. The
//            full and empty flags come from an occupancy counter. A push
//            is ignored while the FIFO is full, and a pop is ignored while
//            it is empty.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 133,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    output logic      [WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_push;
    logic w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array. It has no reset because the occupancy count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_cmd_issuer
// Purpose  : Sequential front-end for a combinational ALU. The module
//            buffers commands in a FIFO and holds each command on the ALU
//            inputs for SETTLE_CYCLES. It then captures the full-width
//            result and returns results in order over a valid/ready
//            channel.
// Options  : ALU_DIV0_GUARD_EN - when defined, a DIV/MOD command with
//            b == 0 is not issued. It is answered at once with rsp_err=1
//            and rsp_data=0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_cmd_issuer_if.slave  bus
);
    localparam int CMD_W = 2*DATA_W + OP_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     alu_a_q, alu_a_d;
    logic [DATA_W-1:0]     alu_b_q, alu_b_d;
    logic [OP_W-1:0]       alu_sel_q, alu_sel_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [OP_W-1:0]       rsp_sel_q, rsp_sel_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [CMD_W-1:0]      w_fifo_wdata;
    logic [CMD_W-1:0]      w_fifo_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_W-1:0]     w_head_a;
    logic [DATA_W-1:0]     w_head_b;
    logic [OP_W-1:0]       w_head_sel;
    logic                  w_head_div0;
    logic                  w_rsp_hs;
    logic                  w_load;

    assign w_fifo_wdata                       = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
    assign {w_head_a, w_head_b, w_head_sel}   = w_fifo_rdata;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.cmd_valid),
        .pop_i   (w_load),
        .wdata_i (w_fifo_wdata),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef ALU_DIV0_GUARD_EN
    assign w_head_div0 = is_div_op(w_head_sel) && (w_head_b == '0);
`else
    assign w_head_div0 = 1'b0;
`endif

    assign w_rsp_hs = rsp_valid_q && bus.rsp_ready;
    // The next command is taken from an idle FSM, or in the same edge that retires the current response.
    assign w_load   = !w_empty && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && w_rsp_hs));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a guarded divide-by-zero skips SETTLE and goes straight to RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    state_d = w_head_div0 ? ST_RESP : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    if (w_load) begin
                        state_d = w_head_div0 ? ST_RESP : ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: settle countdown, result capture, response retire and command issue
    always_comb begin
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == ST_SETTLE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.alu_c;
                rsp_sel_d   = alu_sel_q;
                rsp_err_d   = 1'b0;
            end
        end

        if ((state_q == ST_RESP) && w_rsp_hs) begin
            rsp_valid_d = 1'b0;
        end

        if (w_load) begin
            if (w_head_div0) begin
                // The ALU is not driven, so it keeps the previous operands
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_sel_d   = w_head_sel;
                rsp_err_d   = 1'b1;
            end else begin
                alu_a_d   = w_head_a;
                alu_b_d   = w_head_b;
                alu_sel_d = w_head_sel;
                cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
            end
        end
    end

    // Datapath registers. Reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_sel   = rsp_sel_q;
`ifdef ALU_DIV0_GUARD_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.busy      = (state_q != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_cmd_issuer
// Purpose  : Self-checking bench for alu_cmd_issuer. The bench drives a
//            behavioural ALU and keeps an in-order response model. It uses
//            table vectors, hand-written corner sequences and randomized
//            traffic. ALU_DIV0_GUARD_EN selects the expected divide-by-zero
//            behaviour.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_cmd_issuer;
    localparam int DW     = 64;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
`ifdef ALU_DIV0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        logic [4:0]   sel;
        logic         err;
    } rsp_t;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [4:0]   sel;
        logic [127:0] exp_data;
        logic         exp_err;
        int           exp_lat;
        logic [4:0]   exp_alu_sel;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_push = 0;
    int   n_rsp  = 0;
    int   push_cyc = 0;

    rsp_t         sb[$];
    int           hs_cyc[$];
    logic [127:0] rsp_log[$];

    alu_cmd_issuer_if #(.DATA_W(DW)) bus();

    alu_cmd_issuer #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: full-width results. A divide by zero gives all ones, and unknown codes return {b,a}.
    function automatic logic [127:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [4:0] s);
        case (s)
            5'd0:    return 128'(a) + 128'(b);
            5'd1:    return 128'(a) - 128'(b);
            5'd2:    return 128'(a) * 128'(b);
            5'd3:    return (b == 0) ? {128{1'b1}} : 128'(a / b);
            5'd4:    return (b == 0) ? {128{1'b1}} : 128'(a % b);
            default: return {b, a};
        endcase
    endfunction

    always_comb bus.alu_c = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

    function automatic rsp_t model(input logic [63:0] a, input logic [63:0] b, input logic [4:0] s);
        rsp_t r;
        if (GUARD && (s == 5'd3 || s == 5'd4) && b == 0) begin
            r.data = '0; r.sel = s; r.err = 1'b1;
        end else begin
            r.data = alu_fn(a, b, s); r.sel = s; r.err = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record accepted commands, score responses in order, and verify that stalled responses hold
    rsp_t         m_exp;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [4:0]   prev_sel;
    logic         prev_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 128'(bus.rsp_valid), 128'(1));
                check("hold_data",  bus.rsp_data, prev_data);
                check("hold_sel",   128'(bus.rsp_sel), 128'(prev_sel));
                check("hold_err",   128'(bus.rsp_err), 128'(prev_err));
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                sb.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
                n_push++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs_cyc.push_back(cyc);
                rsp_log.push_back(bus.rsp_data);
                n_rsp++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got response %0h expected none", bus.rsp_data);
                end else begin
                    m_exp = sb.pop_front();
                    check("sb_data", bus.rsp_data, m_exp.data);
                    check("sb_sel",  128'(bus.rsp_sel), 128'(m_exp.sel));
                    check("sb_err",  128'(bus.rsp_err), 128'(m_exp.err));
                end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_data  = bus.rsp_data;
            prev_sel   = bus.rsp_sel;
            prev_err   = bus.rsp_err;
        end
    end

    // Present one command and hold it until accepted. This is called at posedge+1 and returns at posedge+1.
    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [4:0] s);
        bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = s;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk); #1;
                push_cyc      = cyc;
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL push_timeout: got cmd_ready=0 for 200 cycles expected acceptance");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        c = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                c = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL rsp_timeout: got rsp_valid=0 for 50 cycles expected 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy && !bus.rsp_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL drain_timeout: got busy=%0d pending=%0d expected idle", bus.busy, sb.size());
    endtask

    vec_t tv[10];
    int   rc;
    int   base;

    initial begin
        tv[0] = '{64'd100, 64'd50, 5'd0, 128'd150, 1'b0, SETTLE+1, 5'd0};
        tv[1] = '{64'd200, 64'd75, 5'd1, 128'd125, 1'b0, SETTLE+1, 5'd1};
        tv[2] = '{64'd3,   64'd4,  5'd2, 128'd12,  1'b0, SETTLE+1, 5'd2};
        tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 128'h1_0000_0000_0000_0000, 1'b0, SETTLE+1, 5'd0};
        tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0, SETTLE+1, 5'd2};
        tv[5] = '{64'd500, 64'd7, 5'd3, 128'd71, 1'b0, SETTLE+1, 5'd3};
        tv[6] = '{64'd500, 64'd7, 5'd4, 128'd3,  1'b0, SETTLE+1, 5'd4};
        tv[7] = '{64'd5,   64'd9, 5'd31, 128'h0000_0000_0000_0009_0000_0000_0000_0005, 1'b0, SETTLE+1, 5'd31};
`ifdef ALU_DIV0_GUARD_EN
        tv[8] = '{64'd500, 64'd0, 5'd3, 128'd0, 1'b1, 1, 5'd31};
        tv[9] = '{64'd7,   64'd0, 5'd4, 128'd0, 1'b1, 1, 5'd31};
`else
        tv[8] = '{64'd500, 64'd0, 5'd3, {128{1'b1}}, 1'b0, SETTLE+1, 5'd3};
        tv[9] = '{64'd7,   64'd0, 5'd4, {128{1'b1}}, 1'b0, SETTLE+1, 5'd4};
`endif

        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
        bus.rsp_ready = 1'b1;

        // Asynchronous reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst_alu_a",     128'(bus.alu_a),     128'(0));
        check("rst_alu_sel",   128'(bus.alu_sel),   128'(0));
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check("rst_busy",      128'(bus.busy),      128'(0));
        check("rst_rsp_data",  bus.rsp_data,        128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table: data, opcode, error flag, latency and the ALU opcode left on the bus
        for (int i = 0; i < 10; i++) begin
            push(tv[i].a, tv[i].b, tv[i].sel);
            wait_rsp(rc);
            check($sformatf("tv%0d_lat", i),     128'(rc - push_cyc), 128'(tv[i].exp_lat));
            check($sformatf("tv%0d_data", i),    bus.rsp_data, tv[i].exp_data);
            check($sformatf("tv%0d_sel", i),     128'(bus.rsp_sel), 128'(tv[i].sel));
            check($sformatf("tv%0d_err", i),     128'(bus.rsp_err), 128'(tv[i].exp_err));
            check($sformatf("tv%0d_alu_sel", i), 128'(bus.alu_sel), 128'(tv[i].exp_alu_sel));
            @(posedge clk); #1;
        end
        drain();

        // Backpressure: 1 command issued plus 4 queued, then the sixth command stalls
        bus.rsp_ready = 1'b0;
        base = n_push;
        rsp_log.delete();
        for (int i = 0; i < 5; i++) push(64'd200, 64'(75 + i), 5'd1);
        bus.cmd_valid = 1'b1; bus.cmd_a = 64'd200; bus.cmd_b = 64'd80; bus.cmd_sel = 5'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", 128'(bus.cmd_ready), 128'(0));
            check("bp_rsp_data",  bus.rsp_data, 128'd125);
        end
        check("bp_accepted", 128'(n_push - base), 128'(5));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 100 && bus.cmd_valid; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk); #1;
                bus.cmd_valid = 1'b0;
            end
        end
        drain();
        check("bp_rsp_count", 128'(rsp_log.size()), 128'(6));
        for (int i = 0; i < 6 && i < rsp_log.size(); i++)
            check($sformatf("bp_order%0d", i), rsp_log[i], 128'(125 - i));

        // Back-to-back commands: the response spacing is SETTLE+1
        hs_cyc.delete();
        push(64'd1, 64'd2, 5'd0);
        push(64'd3, 64'd4, 5'd2);
        drain();
        check("b2b_count", 128'(hs_cyc.size()), 128'(2));
        if (hs_cyc.size() == 2)
            check("b2b_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'(SETTLE + 1));

        // Randomized traffic with random response backpressure
        begin
            bit rdone = 1'b0;
            fork
                begin
                    for (int n = 0; n < 150; n++) begin
                        logic [63:0] ra, rb;
                        logic [4:0]  rs;
                        int          pick;
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        pick = $urandom_range(0, 5);
                        rs   = (pick < 5) ? 5'(pick) : 5'($urandom_range(5, 31));
                        ra   = {$urandom, $urandom};
                        rb   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
                        push(ra, rb, rs);
                    end
                    rdone = 1'b1;
                end
                begin
                    while (!rdone) begin
                        @(posedge clk); #1;
                        bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
        end
        bus.rsp_ready = 1'b1;
        drain();
        check("rand_balance", 128'(n_rsp), 128'(n_push));

        // Reset during SETTLE with two commands queued
        bus.rsp_ready = 1'b0;
        push(64'd10, 64'd1, 5'd0);
        push(64'd20, 64'd2, 5'd0);
        push(64'd30, 64'd3, 5'd0);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        check("rst2_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst2_alu_a",     128'(bus.alu_a),     128'(0));
        check("rst2_alu_b",     128'(bus.alu_b),     128'(0));
        check("rst2_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check("rst2_busy",      128'(bus.busy),      128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
            check("post_rst_busy",      128'(bus.busy),      128'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
